// File: rtl/stream_pkg.sv
// Shared types and defaults for the streaming slice sequencer.
// Direction and FSM encodings are used by both the sequencer and the placement logic.
package stream_pkg;

    localparam int unsigned STREAM_WIDTH = 24;

    typedef enum logic {
        STREAM_RIGHT = 1'b0,
        STREAM_LEFT  = 1'b1
    } stream_dir_e;

    typedef enum logic [1:0] {
        IDLE,
        SLICE,
        DONE
    } seq_state_e;

endpackage

// File: rtl/stream_slice_place.sv
// Combinational write of one right-aligned slice into the accumulator.
// Right: ptr is the top bit of the slice. Left: ptr is the bottom bit of the slice.
module stream_slice_place
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = STREAM_WIDTH,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] slice_bits,
    input  logic [LEN_W:0]   w,
    input  logic [LEN_W:0]   ptr,
    input  stream_dir_e      dir,
    output logic [WIDTH-1:0] acc_next
);

    localparam logic [LEN_W:0] WIDTH_L = (LEN_W + 1)'(WIDTH);
    localparam logic [LEN_W:0] ONE_L   = (LEN_W + 1)'(1);

    logic [LEN_W:0]   pos;
    logic [WIDTH-1:0] mask;

    always_comb begin
        pos  = '0;
        mask = '0;
        if (dir == STREAM_LEFT) begin
            pos = ptr;
        end else begin
            pos = ptr + ONE_L - w;
        end
        // Mask confines the write to exactly w bits, so nothing outside the stream region is touched.
        mask     = {WIDTH{1'b1}} >> (WIDTH_L - w);
        mask     = mask << pos;
        acc_next = (acc & ~mask) | ((slice_bits << pos) & mask);
    end

endmodule

// File: rtl/stream_slice_sequencer.sv
// Sequenced streaming reorder: one slice per clock, >> preserves slice order, << reverses it.
// Result is left-justified and zero-filled below the stream length.
module stream_slice_sequencer
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = STREAM_WIDTH,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic [LEN_W-1:0] in_slice,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LEN_W-1:0] out_slices,
    output logic             busy
);

    localparam logic [LEN_W:0]   WIDTH_L = (LEN_W + 1)'(WIDTH);
    localparam logic [LEN_W:0]   TOP_L   = (LEN_W + 1)'(WIDTH - 1);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    seq_state_e       state;
    stream_dir_e      dir;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] acc;
    logic [LEN_W:0]   ptr;
    logic [LEN_W:0]   rem;
    logic [LEN_W:0]   slice_sz;
    logic [LEN_W-1:0] cnt;

    logic [LEN_W:0]   len_c;
    logic [LEN_W:0]   slice_c;
    logic [WIDTH-1:0] s_init;
    logic [LEN_W:0]   w;
    logic [WIDTH-1:0] slice_bits;
    logic [WIDTH-1:0] acc_next;

    // Request normalisation: clamp length, map slice 0 to full width, cap slice at length.
    always_comb begin
        len_c   = {1'b0, in_len};
        slice_c = {1'b0, in_slice};
        s_init  = '0;
        if (len_c > WIDTH_L) begin
            len_c = WIDTH_L;
        end
        if (slice_c == '0) begin
            slice_c = WIDTH_L;
        end
        if (slice_c > len_c) begin
            slice_c = len_c;
        end
        s_init = in_data & ({WIDTH{1'b1}} >> (WIDTH_L - len_c));
        s_init = s_init << (WIDTH_L - len_c);
    end

    always_comb begin
        w          = (slice_sz < rem) ? slice_sz : rem;
        slice_bits = s_reg >> (WIDTH_L - w);
    end

    stream_slice_place #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_place (
        .acc        (acc),
        .slice_bits (slice_bits),
        .w          (w),
        .ptr        (ptr),
        .dir        (dir),
        .acc_next   (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir        <= STREAM_RIGHT;
            s_reg      <= '0;
            acc        <= '0;
            ptr        <= '0;
            rem        <= '0;
            slice_sz   <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_slices <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dir      <= stream_dir_e'(in_dir);
                        s_reg    <= s_init;
                        acc      <= '0;
                        rem      <= len_c;
                        slice_sz <= slice_c;
                        cnt      <= '0;
                        ptr      <= (in_dir == STREAM_LEFT) ? (WIDTH_L - len_c) : TOP_L;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (len_c == '0) ? DONE : SLICE;
                    end
                end
                SLICE: begin
                    s_reg <= s_reg << w;
                    acc   <= acc_next;
                    ptr   <= (dir == STREAM_LEFT) ? (ptr + w) : (ptr - w);
                    rem   <= rem - w;
                    cnt   <= cnt + CNT_ONE;
                    if (rem == w) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle latches the result; later cycles hold it until taken.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_data   <= acc;
                        out_slices <= cnt;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_slice_sequencer.sv
// Directed bench for stream_slice_sequencer with hand-computed expected results.
module tb_stream_slice_sequencer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned LEN_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic [LEN_W-1:0] in_slice;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LEN_W-1:0] out_slices;
    logic             busy;

    int tests_run;
    int tests_failed;

    stream_slice_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_slice   (in_slice),
        .in_dir     (in_dir),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_slices (out_slices),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic d, input logic [4:0] sl,
                        input logic [4:0] ln, input logic [23:0] data);
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_dir   = d;
        in_slice = sl;
        in_len   = ln;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle count is the number of edges after the accept edge until out_valid is seen.
    task automatic wait_result(input string tag, input logic [23:0] exp_d,
                               input int exp_s, input int exp_lat);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check_eq({tag, "_slices"}, 32'(out_slices), 32'(exp_s));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] held;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_slice  = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_slices", 32'(out_slices), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        send("r8", 1'b0, 5'd8, 5'd24, 24'h060708);
        wait_result("r8", 24'h060708, 3, 4);
        consume("r8");

        send("l8", 1'b1, 5'd8, 5'd24, 24'h060708);
        wait_result("l8", 24'h080706, 3, 4);
        consume("l8");

        send("l1", 1'b1, 5'd1, 5'd24, 24'h060708);
        wait_result("l1", 24'h10E060, 24, 25);
        consume("l1");

        send("l7", 1'b1, 5'd7, 5'd24, 24'h060708);
        wait_result("l7", 24'h184083, 4, 5);
        consume("l7");

        // Upper bits above len must be discarded.
        send("r7_16", 1'b0, 5'd7, 5'd16, 24'hAB0708);
        wait_result("r7_16", 24'h070800, 3, 4);
        consume("r7_16");

        send("l7_16", 1'b1, 5'd7, 5'd16, 24'hAB0708);
        wait_result("l7_16", 24'h210300, 3, 4);
        consume("l7_16");

        send("l0sl", 1'b1, 5'd0, 5'd24, 24'h060708);
        wait_result("l0sl", 24'h060708, 1, 2);
        consume("l0sl");

        send("len0", 1'b1, 5'd8, 5'd0, 24'hFFFFFF);
        wait_result("len0", 24'h000000, 0, 1);
        consume("len0");

        send("len30", 1'b1, 5'd8, 5'd30, 24'h060708);
        wait_result("len30", 24'h080706, 3, 4);
        consume("len30");

        // Backpressure: result held, new requests ignored.
        out_ready = 1'b0;
        send("bp", 1'b0, 5'd8, 5'd24, 24'h060708);
        wait_result("bp", 24'h060708, 3, 4);
        held = out_data;
        in_valid = 1'b1;
        in_dir   = 1'b1;
        in_slice = 5'd4;
        in_len   = 5'd12;
        in_data  = 24'h000ABC;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_data", 32'(out_data), 32'(held));
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume("bp");

        // Reset mid-SLICE discards the partial result.
        send("rstmid", 1'b1, 5'd1, 5'd24, 24'h060708);
        @(posedge clk);
        #1;
        check_eq("rstmid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rstmid_valid", 32'(out_valid), 32'd0);
        check_eq("rstmid_data", 32'(out_data), 32'd0);
        check_eq("rstmid_in_ready", 32'(in_ready), 32'd1);
        check_eq("rstmid_busy", 32'(busy), 32'd0);

        send("after", 1'b1, 5'd7, 5'd24, 24'h060708);
        wait_result("after", 24'h184083, 4, 5);
        consume("after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
